gc_mxr_n: RTL and testbench
===========================

GC_MXR_N -- requirements
Module: gc_mxr_n

Interface
REQ-001 SHALL have parameter NCH, 4: number of requesting GC channels, legal range 2..8.
REQ-002 SHALL have parameter AW, 64: width of each host update address.
REQ-003 SHALL have parameter GAP, 2: idle cycles enforced after each completed update, legal range 1..15.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port gc_addr_in, input, NCH*AW: channel i update address in bits [i*AW +: AW].
REQ-007 SHALL have port gc_updt_in, input, NCH: per-channel update request, level.
REQ-008 SHALL have port gc_updt_ack_out, output, NCH: per-channel acknowledge, one-cycle pulse.
REQ-009 SHALL have port gc_addr, output, AW: address of the granted update.
REQ-010 SHALL have port gc_updt, output, 1: downstream update request, level.
REQ-011 SHALL have port gc_updt_ack, input, 1: downstream acknowledge, one-cycle pulse.
REQ-012 SHALL have port gnt_idx, output, 3: index of the current or last granted channel.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ARB, WAIT_ACK and GAP.
REQ-015 In IDLE, when any gc_updt_in bit is high, the block SHALL go to ARB on the next edge; otherwise it SHALL stay in IDLE.
REQ-016 ARB SHALL select the first requesting channel in round-robin order, starting at (ptr+1) mod NCH and wrapping from NCH-1 to 0, where ptr is the last served channel.
REQ-017 In ARB, the block SHALL register gnt_idx and gc_addr from the selected channel's slice.
REQ-018 In ARB, the block SHALL assert gc_updt on the same edge and go to WAIT_ACK.
REQ-019 If all requests drop between IDLE and ARB, the block SHALL return to IDLE with no grant and ptr unchanged.
REQ-020 In WAIT_ACK, gc_updt and gc_addr SHALL be held stable until gc_updt_ack is sampled high, with no timeout.
REQ-021 On gc_updt_ack, on the next edge the block SHALL:
- deassert gc_updt;
- pulse gc_updt_ack_out[gnt_idx] for exactly one cycle;
- set ptr to gnt_idx;
- load the gap counter with GAP;
- enter GAP.
REQ-022 Latency from request to gc_updt (idle block, single request) SHALL be 2 cycles.
REQ-023 Latency from gc_updt_ack to gc_updt_ack_out SHALL be 1 cycle.
REQ-024 The GAP counter SHALL decrement each cycle, and the block SHALL go to IDLE when the counter reaches 0.
REQ-025 In GAP, requests SHALL NOT be sampled, so that a requester that drops gc_updt_in one cycle after its ack is never re-granted.
REQ-026 A gc_updt_ack received outside WAIT_ACK SHALL be ignored.
REQ-027 A grant's gc_updt_in withdrawn during WAIT_ACK SHALL be ignored; the transaction SHALL complete and the ack pulse SHALL still be issued.
REQ-028 At most one gc_updt_ack_out bit SHALL be high in any cycle, and gc_updt SHALL never be high in IDLE or GAP.
REQ-029 With all NCH channels requesting continuously, each channel SHALL be served exactly once per NCH grants.
REQ-030 Request inputs for channels at or above NCH SHALL NOT exist; gnt_idx bits above clog2(NCH) SHALL be 0.

Reset
REQ-031 While rst is low, the block SHALL hold:
- state IDLE;
- gc_updt 0, gc_updt_ack_out all 0, gc_addr 0, gnt_idx 0, busy 0;
- gap counter 0;
- ptr NCH-1, so that channel 0 has first priority.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction immediately with no ack pulse, and the first grant after release SHALL follow REQ-016 from ptr = NCH-1.
REQ-033 Reset SHALL be applied asynchronously and released synchronously to clk.

Verification
REQ-034 Single request: NCH=4, ch2 requests with addr 0x1000 at cycle 0 and the downstream acks at cycle 5 -> gc_updt high over cycles 2..5 with gc_addr 0x1000 and gnt_idx 2, gc_updt_ack_out = 4'b0100 at cycle 6, busy low at cycle 9 (GAP=2).
REQ-035 Round robin: all four channels request continuously and the downstream acks 1 cycle after each gc_updt -> grant order 0,1,2,3,0,1, with no channel granted twice in 4 grants.
REQ-036 Wrap and skip: ptr=3 with ch1 and ch3 requesting -> ch1 granted first, then ch3.
REQ-037 Withdrawal: ch0 drops its request during WAIT_ACK -> transaction completes and gc_updt_ack_out[0] still pulses once. ch0 drops before ARB -> return to IDLE, no gc_updt.
REQ-038 Reset mid-op: rst driven low during WAIT_ACK -> gc_updt is 0 asynchronously and no ack is issued. After release, with ch0 and ch3 requesting -> ch0 is granted.
REQ-039 Spurious ack: gc_updt_ack pulsed in IDLE and in GAP -> no state change and no gc_updt_ack_out pulse.

Source files
------------

// File: rtl/gc_mxr_n.sv
// Round-robin mixer that funnels NCH GC update channels onto one downstream
// update port, with a fixed idle gap after each completed update.
module gc_mxr_n #(
    parameter int NCH = 4,
    parameter int AW  = 64,
    parameter int GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*AW-1:0] gc_addr_in,
    input  logic [NCH-1:0]    gc_updt_in,
    output logic [NCH-1:0]    gc_updt_ack_out,
    output logic [AW-1:0]     gc_addr,
    output logic              gc_updt,
    input  logic              gc_updt_ack,
    output logic [2:0]        gnt_idx,
    output logic              busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARB      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t          state_r;
    logic            rst_meta_r;
    logic            rst_sync_r;
    logic [IW-1:0]   ptr_r;
    logic [3:0]      gap_cnt_r;
    logic [2:0]      gnt_idx_r;
    logic [AW-1:0]   gc_addr_r;
    logic            gc_updt_r;
    logic [NCH-1:0]  ack_out_r;
    logic            busy_r;

    logic            sel_found_s;
    logic [IW-1:0]   sel_idx_s;
    logic [3:0]      sum_s;
    logic [AW-1:0]   addr_sel_s;

    function automatic logic [NCH-1:0] idx_onehot(input logic [IW-1:0] idx);
        logic [NCH-1:0] oh;
        oh = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (IW'(i) == idx) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Reset synchronizer: assertion is immediate, release follows two edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Round-robin search starting one past the last served channel.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        sum_s       = 4'd0;
        for (int i = 1; i <= NCH; i++) begin
            sum_s = 4'(ptr_r) + 4'(i);
            sum_s = (sum_s >= 4'(NCH)) ? (sum_s - 4'(NCH)) : sum_s;
            if (!sel_found_s && gc_updt_in[sum_s[IW-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = sum_s[IW-1:0];
            end else begin
                sel_found_s = sel_found_s;
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // Address mux for the selected channel slice.
    always_comb begin
        addr_sel_s = {AW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (sel_idx_s == IW'(i)) begin
                addr_sel_s = gc_addr_in[i*AW +: AW];
            end else begin
                addr_sel_s = addr_sel_s;
            end
        end
    end

    // Main arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r   <= ST_IDLE;
            ptr_r     <= IW'(NCH - 1);
            gap_cnt_r <= 4'd0;
            gnt_idx_r <= 3'd0;
            gc_addr_r <= {AW{1'b0}};
            gc_updt_r <= 1'b0;
            ack_out_r <= {NCH{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            ack_out_r <= {NCH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (|gc_updt_in) begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    // Requests may have vanished since IDLE; back off without a grant.
                    if (sel_found_s) begin
                        gnt_idx_r <= 3'(sel_idx_s);
                        gc_addr_r <= addr_sel_s;
                        gc_updt_r <= 1'b1;
                        state_r   <= ST_WAIT_ACK;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (gc_updt_ack) begin
                        gc_updt_r <= 1'b0;
                        ack_out_r <= idx_onehot(gnt_idx_r[IW-1:0]);
                        ptr_r     <= gnt_idx_r[IW-1:0];
                        gap_cnt_r <= 4'(GAP);
                        state_r   <= ST_GAP;
                    end else begin
                        state_r   <= ST_WAIT_ACK;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gc_updt_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign gc_updt_ack_out = ack_out_r;
    assign gc_addr         = gc_addr_r;
    assign gc_updt         = gc_updt_r;
    assign gnt_idx         = gnt_idx_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_gc_mxr_n.sv
// Directed self-checking bench for gc_mxr_n (NCH=4, AW=64, GAP=2).
module tb_gc_mxr_n;

    localparam int NCH = 4;
    localparam int AW  = 64;
    localparam int GAP = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH*AW-1:0] gc_addr_in = '0;
    logic [NCH-1:0]    gc_updt_in = '0;
    logic [NCH-1:0]    gc_updt_ack_out;
    logic [AW-1:0]     gc_addr;
    logic              gc_updt;
    logic              gc_updt_ack = 1'b0;
    logic [2:0]        gnt_idx;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    gc_mxr_n #(.NCH(NCH), .AW(AW), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .gc_addr_in(gc_addr_in), .gc_updt_in(gc_updt_in),
        .gc_updt_ack_out(gc_updt_ack_out), .gc_addr(gc_addr), .gc_updt(gc_updt),
        .gc_updt_ack(gc_updt_ack), .gnt_idx(gnt_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] val);
        gc_addr_in[ch*AW +: AW] = val;
    endtask

    task automatic do_reset();
        gc_updt_in  = '0;
        gc_updt_ack = 1'b0;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step(); step(); step();
    endtask

    task automatic wait_updt(output bit ok);
        int k = 0;
        while (!gc_updt && k < 30) begin
            step();
            k++;
        end
        ok = gc_updt;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while (busy && k < 30) begin
            step();
            k++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        gc_updt_in = 4'b1111;
        gc_updt_ack = 1'b1;
        #3;
        tests_run++; if (gc_updt !== 1'b0) begin tests_failed++; $display("FAIL reset_updt: got %0b want 0", gc_updt); end
        tests_run++; if (gc_updt_ack_out !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack_out: got %b want 0000", gc_updt_ack_out); end
        tests_run++; if (gc_addr !== 64'd0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", gc_addr); end
        tests_run++; if (gnt_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx); end
        step(); step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        do_reset();
        wait_idle(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL reset_idle: busy stuck high"); end
    endtask

    task automatic test_single();
        set_addr(2, 64'h1000);
        gc_updt_in = 4'b0100;
        tests_run++; if (gc_updt !== 1'b0) begin tests_failed++; $display("FAIL single_c0_updt: got %0b want 0", gc_updt); end
        step();
        tests_run++; if (gc_updt !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_c1: updt %0b busy %0b want 0 1", gc_updt, busy); end
        step();
        tests_run++; if (gc_updt !== 1'b1) begin tests_failed++; $display("FAIL single_c2_updt: got %0b want 1", gc_updt); end
        tests_run++; if (gc_addr !== 64'h1000) begin tests_failed++; $display("FAIL single_c2_addr: got %h want 1000", gc_addr); end
        tests_run++; if (gnt_idx !== 3'd2) begin tests_failed++; $display("FAIL single_c2_gnt: got %0d want 2", gnt_idx); end
        step(); step();
        tests_run++; if (gc_updt !== 1'b1 || gc_addr !== 64'h1000) begin tests_failed++; $display("FAIL single_c4_hold: updt %0b addr %h want 1 1000", gc_updt, gc_addr); end
        step();
        tests_run++; if (gc_updt !== 1'b1) begin tests_failed++; $display("FAIL single_c5_updt: got %0b want 1", gc_updt); end
        gc_updt_ack = 1'b1;
        step();
        gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt !== 1'b0) begin tests_failed++; $display("FAIL single_c6_updt: got %0b want 0", gc_updt); end
        tests_run++; if (gc_updt_ack_out !== 4'b0100) begin tests_failed++; $display("FAIL single_c6_ack: got %b want 0100", gc_updt_ack_out); end
        step();
        gc_updt_in = 4'b0000;
        tests_run++; if (gc_updt_ack_out !== 4'b0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_c7: ack %b busy %0b want 0000 1", gc_updt_ack_out, busy); end
        step();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_c8_busy: got %0b want 1", busy); end
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_c9_busy: got %0b want 0", busy); end
        step();
        tests_run++; if (busy !== 1'b0 || gc_updt !== 1'b0) begin tests_failed++; $display("FAIL single_c10_regrant: busy %0b updt %0b want 0 0", busy, gc_updt); end
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] seen = 4'b0000;
        bit ok;
        do_reset();
        for (int i = 0; i < NCH; i++) set_addr(i, 64'hA000 + 64'(i));
        gc_updt_in = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            wait_updt(ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_timeout: grant %0d never came", g); end
            tests_run++; if (gnt_idx !== 3'(exp_order[g])) begin tests_failed++; $display("FAIL rr_order: grant %0d got ch%0d want ch%0d", g, gnt_idx, exp_order[g]); end
            tests_run++; if (gc_addr !== 64'hA000 + 64'(exp_order[g])) begin tests_failed++; $display("FAIL rr_addr: grant %0d got %h want %h", g, gc_addr, 64'hA000 + 64'(exp_order[g])); end
            if (g < 4) seen[gnt_idx[1:0]] = 1'b1;
            step();
            gc_updt_ack = 1'b1;
            step();
            gc_updt_ack = 1'b0;
            tests_run++; if (gc_updt_ack_out !== 4'(1 << exp_order[g])) begin tests_failed++; $display("FAIL rr_ack: grant %0d got %b want %b", g, gc_updt_ack_out, 4'(1 << exp_order[g])); end
        end
        tests_run++; if (seen !== 4'b1111) begin tests_failed++; $display("FAIL rr_fair: served mask %b want 1111", seen); end
        gc_updt_in = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_wrap_skip();
        bit ok;
        do_reset();
        set_addr(1, 64'h1111);
        set_addr(3, 64'h3333);
        gc_updt_in = 4'b1010;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd1 || gc_addr !== 64'h1111) begin tests_failed++; $display("FAIL wrap_first: got ch%0d addr %h want ch1 1111", gnt_idx, gc_addr); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0010) begin tests_failed++; $display("FAIL wrap_ack1: got %b want 0010", gc_updt_ack_out); end
        gc_updt_in = 4'b1000;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd3 || gc_addr !== 64'h3333) begin tests_failed++; $display("FAIL wrap_second: got ch%0d addr %h want ch3 3333", gnt_idx, gc_addr); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b1000) begin tests_failed++; $display("FAIL wrap_ack3: got %b want 1000", gc_updt_ack_out); end
        gc_updt_in = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_withdraw();
        bit ok;
        set_addr(0, 64'h0C0C);
        gc_updt_in = 4'b0001;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd0) begin tests_failed++; $display("FAIL wd_grant: got ch%0d want ch0", gnt_idx); end
        gc_updt_in = 4'b0000;
        step(); step();
        tests_run++; if (gc_updt !== 1'b1 || gc_addr !== 64'h0C0C) begin tests_failed++; $display("FAIL wd_hold: updt %0b addr %h want 1 0c0c", gc_updt, gc_addr); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0001) begin tests_failed++; $display("FAIL wd_ack: got %b want 0001", gc_updt_ack_out); end
        step();
        tests_run++; if (gc_updt_ack_out !== 4'b0000) begin tests_failed++; $display("FAIL wd_ack_once: got %b want 0000", gc_updt_ack_out); end
        wait_idle(ok);
        // Request vanishes before ARB samples it.
        gc_updt_in = 4'b0001;
        step();
        gc_updt_in = 4'b0000;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wd_arb_busy: got %0b want 1", busy); end
        step();
        tests_run++; if (gc_updt !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL wd_abort: updt %0b busy %0b want 0 0", gc_updt, busy); end
        step();
        tests_run++; if (gc_updt !== 1'b0) begin tests_failed++; $display("FAIL wd_abort_hold: got %0b want 0", gc_updt); end
        set_addr(1, 64'h0101);
        gc_updt_in = 4'b0011;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd1) begin tests_failed++; $display("FAIL wd_ptr_kept: got ch%0d want ch1", gnt_idx); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        gc_updt_in = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_reset_midop();
        bit ok;
        set_addr(2, 64'h2222);
        gc_updt_in = 4'b0100;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd2) begin tests_failed++; $display("FAIL rm_grant: got ch%0d want ch2", gnt_idx); end
        step();
        rst = 1'b0;
        #1;
        tests_run++; if (gc_updt !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rm_async: updt %0b busy %0b want 0 0", gc_updt, busy); end
        gc_updt_ack = 1'b1;
        step();
        gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0000) begin tests_failed++; $display("FAIL rm_no_ack: got %b want 0000", gc_updt_ack_out); end
        set_addr(0, 64'hBEEF0);
        gc_updt_in = 4'b1001;
        #3 rst = 1'b1;
        wait_updt(ok);
        tests_run++; if (!ok || gnt_idx !== 3'd0 || gc_addr !== 64'hBEEF0) begin tests_failed++; $display("FAIL rm_first: got ch%0d addr %h want ch0 beef0", gnt_idx, gc_addr); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0001) begin tests_failed++; $display("FAIL rm_ack: got %b want 0001", gc_updt_ack_out); end
        gc_updt_in = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_spurious();
        bit ok;
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0000 || busy !== 1'b0 || gc_updt !== 1'b0) begin tests_failed++; $display("FAIL sp_idle: ack %b busy %0b updt %0b want 0000 0 0", gc_updt_ack_out, busy, gc_updt); end
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sp_idle_stay: got %0b want 0", busy); end
        set_addr(3, 64'h3333);
        gc_updt_in = 4'b1000;
        wait_updt(ok);
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        gc_updt_in = 4'b0000;
        tests_run++; if (!ok || gc_updt_ack_out !== 4'b1000) begin tests_failed++; $display("FAIL sp_real_ack: got %b want 1000", gc_updt_ack_out); end
        gc_updt_ack = 1'b1; step(); gc_updt_ack = 1'b0;
        tests_run++; if (gc_updt_ack_out !== 4'b0000 || gc_updt !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL sp_gap: ack %b updt %0b busy %0b want 0000 0 1", gc_updt_ack_out, gc_updt, busy); end
        step();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL sp_gap_c8: got %0b want 1", busy); end
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sp_gap_c9: got %0b want 0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_withdraw();
        test_reset_midop();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
